// File: rtl/lfsr_prng_core.sv
// Pseudo-random word generator with runtime Fibonacci/Galois LFSR, seed/tap loading and valid/ready output.
// Optional LFSR_PERIOD_CNT_EN adds a step counter that reports the sequence period (period_o/period_vld_o).
module lfsr_prng_core #(
  parameter int          WIDTH        = 32,
  parameter int          OUT_BITS     = 8,
  parameter logic [63:0] DEFAULT_TAPS = 64'h8020_0003,
  parameter logic [63:0] DEFAULT_SEED = 64'h0000_0001
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                enable_i,
  input  logic                seed_load_i,
  input  logic [WIDTH-1:0]    seed_i,
  input  logic [WIDTH-1:0]    taps_i,
  input  logic                mode_i,
  input  logic                out_ready_i,
  output logic                out_valid_o,
  output logic [OUT_BITS-1:0] out_data_o,
  output logic                seed_err_o,
  output logic [15:0]         word_cnt_o
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [WIDTH-1:0]    period_o,
  output logic                period_vld_o
`endif
);

  localparam int CW = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(OUT_BITS - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} fsm_t;

  fsm_t                fsm_q;
  logic [WIDTH-1:0]    lfsr_q;
  logic [WIDTH-1:0]    taps_q;
  logic                mode_q;
  logic [CW-1:0]       bit_cnt_q;
  logic [OUT_BITS-1:0] word_q;
  logic                out_valid_q;
  logic [OUT_BITS-1:0] out_data_q;
  logic                seed_err_q;
  logic [15:0]         word_cnt_q;

  logic                step_bit;
  logic [WIDTH-1:0]    lfsr_next;
  logic [OUT_BITS-1:0] word_next;
  logic                seed_zero;
  logic [WIDTH-1:0]    seed_eff;
  logic                step;

  always_comb begin
    step_bit  = 1'b0;
    lfsr_next = lfsr_q;
    if (mode_q) begin
      step_bit  = lfsr_q[0];
      lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? taps_q : '0);
    end else begin
      step_bit  = lfsr_q[WIDTH-1];
      lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & taps_q)};
    end
  end

  // First generated bit of a word ends up in the MSB.
  generate
    if (OUT_BITS == 1) begin : g_word_1
      assign word_next = step_bit;
    end else begin : g_word_n
      assign word_next = {word_q[OUT_BITS-2:0], step_bit};
    end
  endgenerate

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_zero = (seed_i == '0);
  assign seed_eff  = seed_zero ? WIDTH'(1) : seed_i;
  assign step      = (fsm_q == FILL) && enable_i && !seed_load_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      fsm_q       <= IDLE;
      lfsr_q      <= DEFAULT_SEED[WIDTH-1:0];
      taps_q      <= DEFAULT_TAPS[WIDTH-1:0];
      mode_q      <= 1'b0;
      bit_cnt_q   <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      seed_err_q  <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      seed_err_q <= 1'b0;
      if (seed_load_i) begin
        lfsr_q      <= seed_eff;
        taps_q      <= taps_i;
        mode_q      <= mode_i;
        seed_err_q  <= seed_zero;
        fsm_q       <= IDLE;
        bit_cnt_q   <= '0;
        word_q      <= '0;
        out_valid_q <= 1'b0;
      end else begin
        case (fsm_q)
          IDLE: begin
            if (enable_i) fsm_q <= FILL;
          end
          FILL: begin
            if (step) begin
              lfsr_q <= lfsr_next;
              word_q <= word_next;
              if (bit_cnt_q == LAST_BIT) begin
                out_data_q  <= word_next;
                out_valid_q <= 1'b1;
                fsm_q       <= HOLD;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          HOLD: begin
            if (out_valid_q && out_ready_i) begin
              word_cnt_q  <= word_cnt_q + 16'd1;
              out_valid_q <= 1'b0;
              bit_cnt_q   <= '0;
              fsm_q       <= enable_i ? FILL : IDLE;
            end
          end
          default: fsm_q <= IDLE;
        endcase
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign seed_err_o  = seed_err_q;
  assign word_cnt_o  = word_cnt_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] step_cnt_q;
  logic [WIDTH-1:0] step_cnt_inc;
  logic [WIDTH-1:0] seed_ref_q;
  logic [WIDTH-1:0] period_q;
  logic             period_vld_q;

  assign step_cnt_inc = (step_cnt_q == '1) ? step_cnt_q : step_cnt_q + 1'b1;

  // The period is the step count at which the state first returns to its seed.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      step_cnt_q   <= '0;
      seed_ref_q   <= DEFAULT_SEED[WIDTH-1:0];
      period_q     <= '0;
      period_vld_q <= 1'b0;
    end else if (seed_load_i) begin
      step_cnt_q   <= '0;
      seed_ref_q   <= seed_eff;
      period_q     <= '0;
      period_vld_q <= 1'b0;
    end else if (step) begin
      step_cnt_q <= step_cnt_inc;
      if (!period_vld_q && (lfsr_next == seed_ref_q)) begin
        period_q     <= step_cnt_inc;
        period_vld_q <= 1'b1;
      end
    end
  end

  assign period_o     = period_q;
  assign period_vld_o = period_vld_q;
`endif

endmodule

// File: tb/tb_lfsr_prng_core.sv
// Directed self-checking bench for lfsr_prng_core with WIDTH=4, OUT_BITS=4, taps 0xC.
// Exercises period reporting as well when LFSR_PERIOD_CNT_EN is defined.
module tb_lfsr_prng_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       seed_load;
  logic [3:0] seed;
  logic [3:0] taps;
  logic       mode;
  logic       ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       seed_err;
  logic [15:0] word_cnt;
`ifdef LFSR_PERIOD_CNT_EN
  logic [3:0] period;
  logic       period_vld;
`endif

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int n;

  lfsr_prng_core #(
    .WIDTH(4), .OUT_BITS(4), .DEFAULT_TAPS(64'hC), .DEFAULT_SEED(64'h1)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .enable_i(enable), .seed_load_i(seed_load),
    .seed_i(seed), .taps_i(taps), .mode_i(mode), .out_ready_i(ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .seed_err_o(seed_err),
    .word_cnt_o(word_cnt)
`ifdef LFSR_PERIOD_CNT_EN
    , .period_o(period), .period_vld_o(period_vld)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_load(input logic [3:0] s, input logic [3:0] t, input logic m);
    @(negedge clk);
    enable = 1'b0; ready = 1'b0;
    seed_load = 1'b1; seed = s; taps = t; mode = m;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!out_valid && cycles < max_cycles);
  endtask

  task automatic drain();
    enable = 1'b0; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; seed_load = 1'b0; seed = '0; taps = '0; mode = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_data, seed_err, word_cnt} !== 22'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h err=%b cnt=%0d, expected all zero", out_valid, out_data, seed_err, word_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_valid: got %b expected 0", out_valid); end
    // Default state/taps with Fibonacci mode give words 0x1 then 0x3.
    enable = 1'b1; ready = 1'b1;
    wait_valid(20, n);
    checks++;
    if (n !== 5) begin failures++; $display("[TB] FAIL default_latency: got %0d expected 5", n); end
    checks++;
    if (out_data !== 4'h1) begin failures++; $display("[TB] FAIL default_word0: got %h expected 1", out_data); end
    exp_cnt++;
    wait_valid(20, n);
    checks++;
    if (out_data !== 4'h3) begin failures++; $display("[TB] FAIL default_word1: got %h expected 3", out_data); end
    checks++;
    if (word_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL default_cnt: got %0d expected %0d", word_cnt, exp_cnt); end
    drain();
    checks++;
    if (word_cnt !== 16'(exp_cnt) || out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL default_drain: got cnt=%0d valid=%b expected cnt=%0d valid=0", word_cnt, out_valid, exp_cnt);
    end
  endtask

  task automatic test_galois();
    do_load(4'h1, 4'hC, 1'b1);
    checks++;
    if ({out_valid, seed_err} !== 2'b00 || word_cnt !== 16'(exp_cnt)) begin
      failures++; $display("[TB] FAIL galois_load: got valid=%b err=%b cnt=%0d expected 0 0 %0d", out_valid, seed_err, word_cnt, exp_cnt);
    end
    enable = 1'b1; ready = 1'b1;
    wait_valid(20, n);
    checks++;
    if (n !== 5) begin failures++; $display("[TB] FAIL galois_latency: got %0d expected 5", n); end
    checks++;
    if (out_data !== 4'h9) begin failures++; $display("[TB] FAIL galois_word0: got %h expected 9", out_data); end
    exp_cnt++;
    wait_valid(20, n);
    checks++;
    if (n !== 5) begin failures++; $display("[TB] FAIL galois_throughput: got %0d expected 5", n); end
    checks++;
    if (out_data !== 4'hA) begin failures++; $display("[TB] FAIL galois_word1: got %h expected A", out_data); end
    checks++;
    if (word_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL galois_cnt: got %0d expected %0d", word_cnt, exp_cnt); end
    exp_cnt++;
    wait_valid(20, n);
    checks++;
    if (out_data !== 4'hF) begin failures++; $display("[TB] FAIL galois_word2: got %h expected F", out_data); end
    drain();
  endtask

  task automatic test_fibonacci();
    do_load(4'h1, 4'hC, 1'b0);
    enable = 1'b1; ready = 1'b1;
    wait_valid(20, n);
    checks++;
    if (out_data !== 4'h1 || n !== 5) begin failures++; $display("[TB] FAIL fib_word0: got %h after %0d expected 1 after 5", out_data, n); end
    exp_cnt++;
    // Post-word state 0x3 yields 0x3 as the next word.
    wait_valid(20, n);
    checks++;
    if (out_data !== 4'h3) begin failures++; $display("[TB] FAIL fib_word1: got %h expected 3", out_data); end
    drain();
    checks++;
    if (word_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL fib_cnt: got %0d expected %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    do_load(4'h1, 4'hC, 1'b1);
    enable = 1'b1; ready = 1'b0;
    wait_valid(20, n);
    checks++;
    if (out_data !== 4'h9) begin failures++; $display("[TB] FAIL bp_word0: got %h expected 9", out_data); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'h9 || word_cnt !== 16'(exp_cnt)) begin
        failures++; $display("[TB] FAIL bp_hold%0d: got valid=%b data=%h cnt=%0d expected 1 9 %0d", i, out_valid, out_data, word_cnt, exp_cnt);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    exp_cnt++;
    checks++;
    if (word_cnt !== 16'(exp_cnt) || out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL bp_accept: got cnt=%0d valid=%b expected %0d 0", word_cnt, out_valid, exp_cnt);
    end
    wait_valid(20, n);
    checks++;
    if (out_data !== 4'hA || n !== 4) begin failures++; $display("[TB] FAIL bp_word1: got %h after %0d expected A after 4", out_data, n); end
    drain();
  endtask

  task automatic test_zero_seed_abort();
    do_load(4'h1, 4'hC, 1'b1);
    enable = 1'b1; ready = 1'b1;
    repeat (3) @(negedge clk);
    seed_load = 1'b1; seed = 4'h0; taps = 4'hC; mode = 1'b1; enable = 1'b0;
    @(negedge clk);
    seed_load = 1'b0;
    checks++;
    if (seed_err !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL zero_err_pulse: got err=%b valid=%b expected 1 0", seed_err, out_valid);
    end
    @(negedge clk);
    checks++;
    if (seed_err !== 1'b0 || out_valid !== 1'b0 || word_cnt !== 16'(exp_cnt)) begin
      failures++; $display("[TB] FAIL zero_err_clear: got err=%b valid=%b cnt=%0d expected 0 0 %0d", seed_err, out_valid, word_cnt, exp_cnt);
    end
    enable = 1'b1;
    wait_valid(20, n);
    checks++;
    if (out_data !== 4'h9 || n !== 5) begin failures++; $display("[TB] FAIL zero_word: got %h after %0d expected 9 after 5", out_data, n); end
    drain();
  endtask

  task automatic test_pause();
    do_load(4'h1, 4'hC, 1'b1);
    enable = 1'b1; ready = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL pause_valid: got %b expected 0", out_valid); end
    enable = 1'b1;
    wait_valid(20, n);
    checks++;
    if (out_data !== 4'h9 || n !== 2) begin failures++; $display("[TB] FAIL pause_word: got %h after %0d expected 9 after 2", out_data, n); end
    drain();
    checks++;
    if (word_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL pause_cnt: got %0d expected %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_load_vs_handshake();
    do_load(4'h1, 4'hC, 1'b1);
    enable = 1'b1; ready = 1'b0;
    wait_valid(20, n);
    seed_load = 1'b1; seed = 4'h5; taps = 4'hC; mode = 1'b1; ready = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || word_cnt !== 16'(exp_cnt)) begin
      failures++; $display("[TB] FAIL lvh_uncounted: got valid=%b cnt=%0d expected 0 %0d", out_valid, word_cnt, exp_cnt);
    end
    wait_valid(20, n);
    checks++;
    if (out_data !== 4'hB || n !== 5) begin failures++; $display("[TB] FAIL lvh_word: got %h after %0d expected B after 5", out_data, n); end
    drain();
  endtask

  task automatic test_reset_mid_hold();
    do_load(4'h1, 4'hC, 1'b1);
    enable = 1'b1; ready = 1'b0;
    wait_valid(20, n);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre_hold: got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || word_cnt !== 16'd0) begin
      failures++; $display("[TB] FAIL rst_async: got valid=%b data=%h cnt=%0d expected 0 0 0", out_valid, out_data, word_cnt);
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

`ifdef LFSR_PERIOD_CNT_EN
  task automatic test_period();
    do_load(4'h1, 4'hC, 1'b1);
    checks++;
    if (period_vld !== 1'b0 || period !== 4'h0) begin
      failures++; $display("[TB] FAIL period_clear: got vld=%b period=%0d expected 0 0", period_vld, period);
    end
    enable = 1'b1; ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_vld && n < 60);
    checks++;
    if (n !== 19) begin failures++; $display("[TB] FAIL period_timing: got %0d cycles expected 19", n); end
    checks++;
    if (period !== 4'd15) begin failures++; $display("[TB] FAIL period_value: got %0d expected 15", period); end
    enable = 1'b0; ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_galois();
    test_fibonacci();
    test_backpressure();
    test_zero_seed_abort();
    test_pause();
    test_load_vs_handshake();
    test_reset_mid_hold();
`ifdef LFSR_PERIOD_CNT_EN
    test_period();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
